// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, field positions, FSM states.
// No logic here; pure constants and packing helpers.
// Not applicable to flow control.
package cp0_pkg;

    // MFC0/MTC0 register numbers
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Status field positions
    localparam int ST_IE_BIT  = 0;
    localparam int ST_EXL_BIT = 1;
    localparam int ST_IM_LSB  = 8;
    localparam int ST_IM_MSB  = 15;

    // Cause field positions
    localparam int CA_EXC_LSB = 2;
    localparam int CA_EXC_MSB = 6;
    localparam int CA_IP_LSB  = 8;
    localparam int CA_IP_MSB  = 15;
    localparam int CA_BD_BIT  = 31;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } cp0_state_e;

    // Assemble the architectural Status word; unimplemented bits read 0.
    function automatic logic [31:0] pack_status(input logic [7:0] im, input logic exl, input logic ie);
        logic [31:0] r;
        r = '0;
        r[ST_IM_MSB:ST_IM_LSB] = im;
        r[ST_EXL_BIT]          = exl;
        r[ST_IE_BIT]           = ie;
        return r;
    endfunction

    // Assemble the architectural Cause word; unimplemented bits read 0.
    function automatic logic [31:0] pack_cause(input logic bd, input logic [7:0] ip, input logic [4:0] code);
        logic [31:0] r;
        r = '0;
        r[CA_BD_BIT]             = bd;
        r[CA_IP_MSB:CA_IP_LSB]   = ip;
        r[CA_EXC_MSB:CA_EXC_LSB] = code;
        return r;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running counter with sticky timer-interrupt pending flag.
// Count and TI update one cycle after the edge; writes take effect at the edge.
// No backpressure; write strobes are accepted unconditionally.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_we,
    input  logic [31:0] count_wdata,
    input  logic        compare_we,
    input  logic [31:0] compare_wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);

    // Count increments every cycle unless overwritten; TI latches on a match and clears on a Compare write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            count <= count_we ? count_wdata : count + 32'd1;
            if (compare_we) begin
                compare <= compare_wdata;
                ti      <= 1'b0;
            end else if ((count == compare) && (compare != '0)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file with exception-entry/ERET sequencer, interrupt arbitration and flush control.
// Event sampled at edge N -> redirect pulse in cycle N+1, flush for cycles N+1..N+FLUSH_CYCLES.
// No backpressure; events arriving while flushing belong to squashed instructions and are dropped.
module cp0_exc_unit
    import cp0_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_4180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        addr_change,
    input  logic [4:0]  exc_code,
    input  logic        in_delay,
    input  logic [31:0] cur_pc,
    input  logic        cur_valid,
    input  logic [31:0] bad_vaddr,
    input  logic        eret,
    input  logic [5:0]  hw_int,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush,
    output logic        status_exl
);

    localparam logic [2:0] FLUSH_LEN = 3'(FLUSH_CYCLES);

    cp0_state_e  state_q, state_d;
    logic [2:0]  flush_cnt_q, flush_cnt_d;
    logic        redirect_d;
    logic [31:0] redirect_pc_d;

    logic [31:0] badvaddr_q, epc_q;
    logic [7:0]  im_q;
    logic        exl_q, ie_q, bd_q;
    logic [1:0]  ip_sw_q;
    logic [4:0]  exc_code_q;

    logic [31:0] count, compare;
    logic        ti;
    logic [7:0]  ip;
    logic        in_run, int_req;
    logic        take_exc, take_int, take_entry, take_eret, take_mtc0;

    // Interrupt pending view and one-event-per-edge arbitration.
    always_comb begin
        ip         = {hw_int[5] | ti, hw_int[4:0], ip_sw_q};
        in_run     = (state_q == ST_RUN);
        int_req    = ie_q & ~exl_q & (|(im_q & ip)) & cur_valid;
        take_exc   = in_run & addr_change;
        take_int   = in_run & ~addr_change & int_req;
        take_entry = take_exc | take_int;
        take_eret  = in_run & ~take_entry & eret;
        take_mtc0  = in_run & ~take_entry & ~eret & mtc0_we;
    end

    cp0_timer u_timer (
        .clk           (clk),
        .reset         (reset),
        .count_we      (take_mtc0 && (cp0_waddr == CP0_COUNT)),
        .count_wdata   (cp0_wdata),
        .compare_we    (take_mtc0 && (cp0_waddr == CP0_COMPARE)),
        .compare_wdata (cp0_wdata),
        .count         (count),
        .compare       (compare),
        .ti            (ti)
    );

    // Sequencer state register: RUN/FLUSH, flush countdown, redirect pulse and target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            redirect    <= redirect_d;
            redirect_pc <= redirect_pc_d;
        end
    end

    // Next-state: an accepted event starts a flush window; FLUSH counts down back to RUN.
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc;
        case (state_q)
            ST_RUN: begin
                if (take_entry || take_eret) begin
                    state_d       = ST_FLUSH;
                    flush_cnt_d   = FLUSH_LEN;
                    redirect_d    = 1'b1;
                    redirect_pc_d = take_entry ? EXC_VECTOR : epc_q;
                end
            end
            ST_FLUSH: begin
                flush_cnt_d = flush_cnt_q - 3'd1;
                if (flush_cnt_q <= 3'd1) begin
                    state_d     = ST_RUN;
                    flush_cnt_d = '0;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Architectural register updates: exception entry, ERET, then MTC0 in falling priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            badvaddr_q <= '0;
            epc_q      <= '0;
            im_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_sw_q    <= '0;
            exc_code_q <= '0;
        end else if (take_entry) begin
            // A nested entry keeps the original return address and BD.
            if (!exl_q) begin
                epc_q <= in_delay ? cur_pc - 32'd4 : cur_pc;
                bd_q  <= in_delay;
            end
            exc_code_q <= take_exc ? exc_code : EXC_INT;
            exl_q      <= 1'b1;
            if (take_exc && ((exc_code == EXC_ADEL) || (exc_code == EXC_ADES))) begin
                badvaddr_q <= bad_vaddr;
            end
        end else if (take_eret) begin
            exl_q <= 1'b0;
        end else if (take_mtc0) begin
            case (cp0_waddr)
                CP0_STATUS: begin
                    im_q  <= cp0_wdata[ST_IM_MSB:ST_IM_LSB];
                    exl_q <= cp0_wdata[ST_EXL_BIT];
                    ie_q  <= cp0_wdata[ST_IE_BIT];
                end
                CP0_CAUSE: ip_sw_q <= cp0_wdata[CA_IP_LSB+1:CA_IP_LSB];
                CP0_EPC:   epc_q   <= cp0_wdata;
                default: ;
            endcase
        end
    end

    // MFC0 read mux on pre-edge register values.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_q;
            CP0_COUNT:    cp0_rdata = count;
            CP0_COMPARE:  cp0_rdata = compare;
            CP0_STATUS:   cp0_rdata = pack_status(im_q, exl_q, ie_q);
            CP0_CAUSE:    cp0_rdata = pack_cause(bd_q, ip, exc_code_q);
            CP0_EPC:      cp0_rdata = epc_q;
            default:      cp0_rdata = '0;
        endcase
    end

    assign flush      = (state_q == ST_FLUSH);
    assign status_exl = exl_q;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Self-checking bench for cp0_exc_unit: directed scenarios plus randomized traffic vs. a reference model.
// Outputs are compared on every falling edge against the model.
// No flow control involved.
module tb_cp0_exc_unit;

    localparam logic [31:0] VEC = 32'h0000_4180;
    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        addr_change;
    logic [4:0]  exc_code;
    logic        in_delay;
    logic [31:0] cur_pc;
    logic        cur_valid;
    logic [31:0] bad_vaddr;
    logic        eret;
    logic [5:0]  hw_int;
    logic        mtc0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic [4:0]  cp0_raddr;
    logic [31:0] cp0_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush;
    logic        status_exl;

    always #20 clk = ~clk;

    cp0_exc_unit #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .reset(reset), .addr_change(addr_change), .exc_code(exc_code),
        .in_delay(in_delay), .cur_pc(cur_pc), .cur_valid(cur_valid), .bad_vaddr(bad_vaddr),
        .eret(eret), .hw_int(hw_int), .mtc0_we(mtc0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .status_exl(status_exl)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state (architectural view)
    logic [31:0] m_badv, m_count, m_compare, m_epc, m_rpc;
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti, m_redirect;
    logic [1:0]  m_ipsw;
    logic [4:0]  m_code;
    int          m_flush_left;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_badv = '0; m_count = '0; m_compare = '0; m_epc = '0; m_rpc = '0;
        m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ti = 0; m_redirect = 0;
        m_ipsw = '0; m_code = '0; m_flush_left = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:  return m_badv;
            5'd9:  return m_count;
            5'd11: return m_compare;
            5'd12: return {16'b0, m_im, 6'b0, m_exl, m_ie};
            5'd13: return {m_bd, 15'b0, hw_int[5] | m_ti, hw_int[4:0], m_ipsw, 1'b0, m_code, 2'b00};
            5'd14: return m_epc;
            default: return 32'h0;
        endcase
    endfunction

    // One clock edge of architectural behaviour, using the inputs present at the edge.
    task automatic model_edge();
        logic [7:0]  ip;
        logic        busy, ev, irq;
        logic [31:0] old_count, old_compare;
        ip = {hw_int[5] | m_ti, hw_int[4:0], m_ipsw};
        busy = (m_flush_left > 0);
        old_count = m_count;
        old_compare = m_compare;
        irq = m_ie && !m_exl && ((m_im & ip) != 8'h0) && cur_valid;
        m_count = m_count + 1;
        if (old_count == old_compare && old_compare != 0) m_ti = 1;
        ev = 0;
        if (!busy) begin
            if (addr_change || irq) begin
                if (!m_exl) begin
                    m_epc = in_delay ? cur_pc - 4 : cur_pc;
                    m_bd = in_delay;
                end
                m_code = addr_change ? exc_code : 5'd0;
                if (addr_change && (exc_code == 5'd4 || exc_code == 5'd5)) m_badv = bad_vaddr;
                m_exl = 1;
                m_rpc = VEC;
                ev = 1;
            end else if (eret) begin
                m_exl = 0;
                m_rpc = m_epc;
                ev = 1;
            end else if (mtc0_we) begin
                case (cp0_waddr)
                    5'd9:  m_count = cp0_wdata;
                    5'd11: begin m_compare = cp0_wdata; m_ti = 0; end
                    5'd12: begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
                    5'd13: m_ipsw = cp0_wdata[9:8];
                    5'd14: m_epc = cp0_wdata;
                    default: ;
                endcase
            end
        end
        m_redirect = ev;
        if (ev) m_flush_left = FC;
        else if (m_flush_left > 0) m_flush_left--;
    endtask

    task automatic check_outputs();
        chk("redirect", {31'b0, redirect}, {31'b0, m_redirect});
        if (m_redirect) chk("redirect_pc", redirect_pc, m_rpc);
        chk("flush", {31'b0, flush}, (m_flush_left > 0) ? 32'd1 : 32'd0);
        chk("status_exl", {31'b0, status_exl}, {31'b0, m_exl});
        for (int a = 7; a <= 15; a++) begin
            cp0_raddr = 5'(a);
            #1;
            chk($sformatf("rd%0d", a), cp0_rdata, m_read(5'(a)));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_raddr = a;
        #1;
        d = cp0_rdata;
    endtask

    task automatic clear_inputs();
        addr_change = 0; exc_code = '0; in_delay = 0; cur_pc = '0; cur_valid = 0;
        bad_vaddr = '0; eret = 0; hw_int = '0; mtc0_we = 0; cp0_waddr = '0;
        cp0_wdata = '0; cp0_raddr = '0;
    endtask

    task automatic settle();
        clear_inputs();
        repeat (FC) cyc();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        clear_inputs();
        mtc0_we = 1; cp0_waddr = a; cp0_wdata = d;
        cyc();
        clear_inputs();
    endtask

    task automatic do_eret();
        clear_inputs();
        eret = 1;
        cyc();
        clear_inputs();
    endtask

    logic [31:0] d;
    int n;
    logic [4:0] wa [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    logic [4:0] ec [4] = '{5'd4, 5'd5, 5'd10, 5'd12};

    initial begin
        clear_inputs();
        reset = 1;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_redirect", {31'b0, redirect}, 32'd0);
        chk("rst_flush", {31'b0, flush}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        rd(5'd14, d); chk("rst_epc", d, 32'd0);
        reset = 0;

        // AdEL entry
        addr_change = 1; exc_code = 5'd4; cur_pc = 32'h3010; bad_vaddr = 32'h1001; cur_valid = 1;
        cyc();
        clear_inputs();
        chk("adel_redirect", {31'b0, redirect}, 32'd1);
        chk("adel_pc", redirect_pc, 32'h4180);
        rd(5'd14, d); chk("adel_epc", d, 32'h3010);
        rd(5'd8, d);  chk("adel_badv", d, 32'h1001);
        rd(5'd13, d); chk("adel_code", {27'b0, d[6:2]}, 32'd4);
        chk("adel_exl", {31'b0, status_exl}, 32'd1);
        n = flush ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n += flush ? 1 : 0;
        end
        chk("adel_flush_len", n, 32'd2);
        do_eret();
        settle();

        // Overflow in a delay slot, then ERET back
        addr_change = 1; exc_code = 5'd12; in_delay = 1; cur_pc = 32'h2004; cur_valid = 1;
        cyc();
        clear_inputs();
        rd(5'd14, d); chk("ov_epc", d, 32'h2000);
        rd(5'd13, d); chk("ov_bd_code", {d[31], 26'b0, d[6:2]}, 32'h8000_000C);
        settle();
        do_eret();
        chk("eret_pc", redirect_pc, 32'h2000);
        chk("eret_exl", {31'b0, status_exl}, 32'd0);
        settle();

        // Nested entry keeps EPC
        mtc0(5'd14, 32'h500);
        mtc0(5'd12, 32'h2);
        addr_change = 1; exc_code = 5'd10; cur_pc = 32'h900; cur_valid = 1;
        cyc();
        clear_inputs();
        chk("nest_pc", redirect_pc, 32'h4180);
        rd(5'd14, d); chk("nest_epc", d, 32'h500);
        rd(5'd13, d); chk("nest_code", {27'b0, d[6:2]}, 32'd10);
        settle();
        do_eret();
        settle();

        // Hardware interrupt
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001; cur_valid = 1; cur_pc = 32'h1234;
        cyc();
        chk("int_redirect", {31'b0, redirect}, 32'd1);
        rd(5'd13, d); chk("int_ip_code", d & 32'h0000_047C, 32'h0000_0400);
        settle();
        do_eret();
        settle();
        mtc0(5'd12, 32'h0);

        // Timer with interrupts disabled
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'h5);
        n = -1;
        for (int i = 0; i < 30 && n < 0; i++) begin
            cyc();
            rd(5'd13, d);
            if (d[15]) begin
                rd(5'd9, d);
                n = int'(d);
            end
        end
        chk("ti_rise_count", n, 32'd6);
        mtc0(5'd11, 32'h100);
        rd(5'd13, d); chk("ti_cleared", {31'b0, d[15]}, 32'd0);

        // Exception + ERET + MTC0 on one edge, then exception during FLUSH
        addr_change = 1; exc_code = 5'd5; cur_pc = 32'h700; bad_vaddr = 32'hABC; cur_valid = 1;
        eret = 1; mtc0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hDEAD;
        cyc();
        clear_inputs();
        chk("cfl_pc", redirect_pc, 32'h4180);
        rd(5'd14, d); chk("cfl_epc", d, 32'h700);
        rd(5'd8, d);  chk("cfl_badv", d, 32'hABC);
        addr_change = 1; exc_code = 5'd4; cur_pc = 32'h800; bad_vaddr = 32'h1; cur_valid = 1;
        cyc();
        clear_inputs();
        chk("inflush_redirect", {31'b0, redirect}, 32'd0);
        rd(5'd8, d); chk("inflush_badv", d, 32'hABC);
        settle();

        // Reset in the middle of a flush window
        do_eret();
        #2 reset = 1;
        #1;
        chk("rstmid_flush", {31'b0, flush}, 32'd0);
        chk("rstmid_redirect", {31'b0, redirect}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 0;
        model_reset();
        check_outputs();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            clear_inputs();
            addr_change = ($urandom_range(0, 99) < 8);
            exc_code = ec[$urandom_range(0, 3)];
            in_delay = $urandom_range(0, 1) == 1;
            cur_pc = {$urandom_range(0, 32'hFFFF), 2'b00};
            cur_valid = ($urandom_range(0, 99) < 80);
            bad_vaddr = $urandom;
            eret = ($urandom_range(0, 99) < 6);
            hw_int = ($urandom_range(0, 99) < 15) ? 6'($urandom) : 6'h0;
            mtc0_we = ($urandom_range(0, 99) < 25);
            cp0_waddr = wa[$urandom_range(0, 6)];
            cp0_wdata = $urandom;
            if (cp0_waddr == 5'd11 && $urandom_range(0, 1) == 1) cp0_wdata = m_count + $urandom_range(2, 20);
            if (cp0_waddr == 5'd9 && $urandom_range(0, 3) != 0) cp0_wdata = m_count;
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
